// File: rtl/can_xl_pkg.sv
// can_xl_pkg: constants and types shared by the CAN XL frame-CRC generator and checker blocks.
package can_xl_pkg;
  localparam int FCRC_W = 32;
  localparam logic [FCRC_W-1:0] FCRC_POLY = 32'hFA567D89;
  typedef enum logic [1:0] {ST_IDLE, ST_RECV, ST_CMP, ST_DONE} fcrc_st_e;
endpackage

// File: rtl/rx_fcrc_chk_if.sv
// rx_fcrc_chk_if: bit stream, clears and result signals between the frame FSM and the FCRC checker.
interface rx_fcrc_chk_if;
  import can_xl_pkg::*;
  logic data, de_stuff, fcrc_chk_en, initialize, tx_success, rx_success;
  logic [FCRC_W-1:0] fcrc_frm, fcrc_rx;
  logic [5:0] fcrc_bit_cnt;
  logic fcrc_busy, fcrc_done, fcrc_ok, fcrc_err;
  modport master (
    output data, de_stuff, fcrc_chk_en, fcrc_frm, initialize, tx_success, rx_success,
    input fcrc_rx, fcrc_bit_cnt, fcrc_busy, fcrc_done, fcrc_ok, fcrc_err
  );
  modport slave (
    input data, de_stuff, fcrc_chk_en, fcrc_frm, initialize, tx_success, rx_success,
    output fcrc_rx, fcrc_bit_cnt, fcrc_busy, fcrc_done, fcrc_ok, fcrc_err
  );
endinterface

// File: rtl/rx_fcrc_chk.sv
// rx_fcrc_chk: snapshots the computed FCRC, shifts in the received FCRC field and reports a sticky pass/fail.
module rx_fcrc_chk #(
  parameter int FCRC_W = can_xl_pkg::FCRC_W
) (
  input logic clk,
  input logic g_rst_n,
  rx_fcrc_chk_if.slave bus
);
  import can_xl_pkg::*;
  fcrc_st_e st;
  logic [FCRC_W-1:0] snap;
  logic acc, clr;
  assign acc = bus.fcrc_chk_en && !bus.de_stuff;
  assign clr = bus.initialize || bus.tx_success || bus.rx_success;
  assign bus.fcrc_busy = (st == ST_RECV) || (st == ST_CMP);
  // Clear outranks every in-flight event, so an aborted frame never reaches CMP.
  always_ff @(posedge clk or negedge g_rst_n)
    if (!g_rst_n || clr) begin
      st <= ST_IDLE;
      snap <= '0;
      bus.fcrc_rx <= '0;
      bus.fcrc_bit_cnt <= '0;
      bus.fcrc_done <= 1'b0;
      bus.fcrc_ok <= 1'b0;
      bus.fcrc_err <= 1'b0;
    end else begin
      bus.fcrc_done <= 1'b0;
      case (st)
        ST_IDLE: if (acc) begin
          snap <= bus.fcrc_frm;
          bus.fcrc_rx <= {{(FCRC_W-1){1'b0}}, bus.data};
          bus.fcrc_bit_cnt <= 6'd1;
          st <= ST_RECV;
        end
        ST_RECV: if (acc) begin
          bus.fcrc_rx <= {bus.fcrc_rx[FCRC_W-2:0], bus.data};
          bus.fcrc_bit_cnt <= bus.fcrc_bit_cnt + 6'd1;
          if (bus.fcrc_bit_cnt == 6'(FCRC_W - 1)) st <= ST_CMP;
        end
        ST_CMP: begin
          bus.fcrc_ok <= bus.fcrc_rx == snap;
          bus.fcrc_err <= bus.fcrc_rx != snap;
          bus.fcrc_done <= 1'b1;
          st <= ST_DONE;
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_rx_fcrc_chk.sv
// tb_rx_fcrc_chk: directed frames against rx_fcrc_chk with hand-computed expectations.
module tb_rx_fcrc_chk;
  logic clk = 1'b0;
  logic g_rst_n = 1'b0;
  int errs = 0;
  int checks = 0;
  int done_cnt = 0;
  int done_ref;
  logic [31:0] w;
  rx_fcrc_chk_if bus ();
  rx_fcrc_chk dut (.clk(clk), .g_rst_n(g_rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) if (bus.fcrc_done) done_cnt++;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic send_bit(input logic d, input logic s);
    bus.data = d;
    bus.de_stuff = s;
    bus.fcrc_chk_en = 1'b1;
    @(posedge clk);
    #1;
    bus.fcrc_chk_en = 1'b0;
    bus.de_stuff = 1'b0;
  endtask
  task automatic send_word(input logic [31:0] v);
    for (int i = 31; i >= 0; i--) send_bit(v[i], 1'b0);
  endtask
  task automatic clr_pulse();
    bus.initialize = 1'b1;
    @(posedge clk);
    #1;
    bus.initialize = 1'b0;
  endtask
  task automatic settle();
    repeat (3) @(posedge clk);
    #1;
  endtask
  initial begin
    bus.data = 1'b0;
    bus.de_stuff = 1'b0;
    bus.fcrc_chk_en = 1'b0;
    bus.fcrc_frm = '0;
    bus.initialize = 1'b0;
    bus.tx_success = 1'b0;
    bus.rx_success = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rx", bus.fcrc_rx, 32'h0);
    chk("rst_cnt", bus.fcrc_bit_cnt, 0);
    chk("rst_flags", {bus.fcrc_busy, bus.fcrc_done, bus.fcrc_ok, bus.fcrc_err}, 0);
    @(negedge clk);
    g_rst_n = 1'b1;
    @(posedge clk);
    #1;
    // clean pass with exact result latency
    bus.fcrc_frm = 32'hDEADBEEF;
    send_word(32'hDEADBEEF);
    chk("pass_cnt", bus.fcrc_bit_cnt, 32);
    chk("pass_rx", bus.fcrc_rx, 32'hDEADBEEF);
    chk("pass_busy_cmp", bus.fcrc_busy, 1);
    chk("pass_done_early", bus.fcrc_done, 0);
    @(posedge clk);
    #1;
    chk("pass_done", bus.fcrc_done, 1);
    chk("pass_ok", bus.fcrc_ok, 1);
    chk("pass_err", bus.fcrc_err, 0);
    chk("pass_busy_done", bus.fcrc_busy, 0);
    @(posedge clk);
    #1;
    chk("pass_done_once", bus.fcrc_done, 0);
    chk("pass_ok_sticky", bus.fcrc_ok, 1);
    // single-bit error: fifth bit from the MSB flipped
    clr_pulse();
    chk("clr_ok", bus.fcrc_ok, 0);
    done_ref = done_cnt;
    w = 32'hDEADBEEF ^ 32'h0800_0000;
    send_word(w);
    settle();
    chk("err_rx", bus.fcrc_rx, 32'hD6ADBEEF);
    chk("err_err", bus.fcrc_err, 1);
    chk("err_ok", bus.fcrc_ok, 0);
    chk("err_done_count", done_cnt - done_ref, 1);
    // stuff bits and late changes on fcrc_frm
    clr_pulse();
    bus.fcrc_frm = 32'hDEADBEEF;
    w = 32'hDEADBEEF;
    send_bit(1'b0, 1'b1);
    chk("stuff_first_cnt", bus.fcrc_bit_cnt, 0);
    chk("stuff_first_busy", bus.fcrc_busy, 0);
    for (int i = 31; i >= 0; i--) begin
      send_bit(w[i], 1'b0);
      if (i == 31) bus.fcrc_frm = 32'h12345678;
      if (i != 0 && (32 - i) % 10 == 0) send_bit(~w[i], 1'b1);
    end
    chk("stuff_cnt", bus.fcrc_bit_cnt, 32);
    settle();
    chk("stuff_ok", bus.fcrc_ok, 1);
    chk("stuff_err", bus.fcrc_err, 0);
    chk("stuff_rx", bus.fcrc_rx, 32'hDEADBEEF);
    // mid-field abort on the 17th accepted bit
    clr_pulse();
    bus.fcrc_frm = 32'hDEADBEEF;
    done_ref = done_cnt;
    for (int i = 31; i >= 16; i--) send_bit(w[i], 1'b0);
    bus.initialize = 1'b1;
    send_bit(w[15], 1'b0);
    bus.initialize = 1'b0;
    chk("abort_rx", bus.fcrc_rx, 32'h0);
    chk("abort_cnt", bus.fcrc_bit_cnt, 0);
    chk("abort_flags", {bus.fcrc_busy, bus.fcrc_done, bus.fcrc_ok, bus.fcrc_err}, 0);
    settle();
    chk("abort_no_done", done_cnt - done_ref, 0);
    bus.fcrc_frm = 32'h0F0F0F0F;
    send_word(32'h0F0F0F0F);
    settle();
    chk("abort_next_ok", bus.fcrc_ok, 1);
    chk("abort_next_rx", bus.fcrc_rx, 32'h0F0F0F0F);
    // clear colliding with the 32nd bit
    clr_pulse();
    bus.fcrc_frm = 32'hDEADBEEF;
    done_ref = done_cnt;
    for (int i = 31; i >= 1; i--) send_bit(w[i], 1'b0);
    bus.rx_success = 1'b1;
    send_bit(w[0], 1'b0);
    bus.rx_success = 1'b0;
    chk("coll_cnt", bus.fcrc_bit_cnt, 0);
    chk("coll_busy", bus.fcrc_busy, 0);
    settle();
    chk("coll_no_done", done_cnt - done_ref, 0);
    chk("coll_flags", {bus.fcrc_ok, bus.fcrc_err}, 0);
    // asynchronous reset mid-field, then strobes after DONE
    for (int i = 31; i >= 22; i--) send_bit(w[i], 1'b0);
    chk("arst_pre_busy", bus.fcrc_busy, 1);
    #2;
    g_rst_n = 1'b0;
    #1;
    chk("arst_rx", bus.fcrc_rx, 32'h0);
    chk("arst_cnt", bus.fcrc_bit_cnt, 0);
    chk("arst_busy", bus.fcrc_busy, 0);
    @(negedge clk);
    g_rst_n = 1'b1;
    @(posedge clk);
    #1;
    bus.fcrc_frm = 32'hDEADBEEF;
    send_word(32'hDEADBEEF);
    settle();
    done_ref = done_cnt;
    for (int i = 0; i < 5; i++) send_bit(1'b0, 1'b0);
    settle();
    chk("done_hold_cnt", bus.fcrc_bit_cnt, 32);
    chk("done_hold_rx", bus.fcrc_rx, 32'hDEADBEEF);
    chk("done_hold_ok", {bus.fcrc_ok, bus.fcrc_err}, 2'b10);
    chk("done_hold_no_done", done_cnt - done_ref, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
